memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_memory_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// memory_arbiter
// Arbitrates a single-ported RAM between an instruction-fetch requester and a
// data requester. Data requests win over fetches. Each accepted request is
// latched and carried through one RAM access, then acknowledged with a
// one-cycle hit pulse.
//
// Ports
//   CLK, nRST            clock, asynchronous active-low reset
//   iREN, iaddr          instruction fetch request (level) and address
//   dREN, dWEN           data read / write request (level)
//   daddr, dstore        data address and write value
//   ihit, iload          fetch done pulse, fetched word (held)
//   dhit, dload          data done pulse, read word (held)
//   ramREN, ramWEN       RAM strobes
//   ramaddr, ramstore    RAM address and write data
//   ramload, ramstate    RAM read data and status (FREE/BUSY/ACCESS/ERROR)
//   merr                 sticky error flag (RAM ERROR or timeout)
module memory_arbiter #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        ihit,
   output logic [31:0] iload,
   output logic        dhit,
   output logic [31:0] dload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate,
   output logic        merr
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMO = CW'(TIMEOUT);
   localparam logic [1:0] RAM_ACCESS = 2'd2;
   localparam logic [1:0] RAM_ERROR  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DACC = 2'd1,
      ST_IACC = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic          wr_q, wr_d;       // latched op: 1 = write
   logic          data_q, data_d;   // latched source: 1 = data port
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   store_q, store_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ihit_q, ihit_d;
   logic          dhit_q, dhit_d;
   logic [31:0]   iload_q, iload_d;
   logic [31:0]   dload_q, dload_d;
   logic          merr_q, merr_d;
   logic          done_s, fail_s;
   logic [31:0]   rdata_s;
   logic          acc_s;

   // Next-state, request latching, completion and timeout logic
   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      data_d  = data_q;
      addr_d  = addr_q;
      store_d = store_q;
      cnt_d   = cnt_q;
      ihit_d  = 1'b0;
      dhit_d  = 1'b0;
      iload_d = iload_q;
      dload_d = dload_q;
      merr_d  = merr_q;
      done_s  = 1'b0;
      fail_s  = 1'b0;
      rdata_s = 32'h0000_0000;
      case (state_q)
         ST_IDLE: begin
            // Counter is cleared here so every access starts from zero.
            cnt_d = {CW{1'b0}};
            if (dREN || dWEN) begin
               state_d = ST_DACC;
               wr_d    = dWEN;   // read+write together is a write
               data_d  = 1'b1;
               addr_d  = daddr;
               store_d = dstore;
            end else if (iREN) begin
               state_d = ST_IACC;
               wr_d    = 1'b0;
               data_d  = 1'b0;
               addr_d  = iaddr;
               store_d = 32'h0000_0000;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DACC, ST_IACC: begin
            if (ramstate == RAM_ACCESS) begin
               done_s  = 1'b1;
               rdata_s = ramload;
            end else if (ramstate == RAM_ERROR) begin
               done_s = 1'b1;
               fail_s = 1'b1;
            end else begin
               cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
               // The TIMEOUT-th pending cycle completes as an error.
               if (cnt_d == TMO) begin
                  done_s = 1'b1;
                  fail_s = 1'b1;
               end else begin
                  done_s = 1'b0;
               end
            end
            if (done_s) begin
               state_d = ST_RESP;
               merr_d  = merr_q | fail_s;
               if (data_q) begin
                  dhit_d = 1'b1;
                  if (!wr_q) begin
                     dload_d = rdata_s;
                  end else begin
                     dload_d = dload_q;
                  end
               end else begin
                  ihit_d  = 1'b1;
                  iload_d = rdata_s;
               end
            end else begin
               state_d = state_q;
            end
         end
         ST_RESP: begin
            // Hit is visible this cycle; requester drops its request now.
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, request latch, counter and response registers
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= ST_IDLE;
         wr_q    <= 1'b0;
         data_q  <= 1'b0;
         addr_q  <= 32'h0000_0000;
         store_q <= 32'h0000_0000;
         cnt_q   <= {CW{1'b0}};
         ihit_q  <= 1'b0;
         dhit_q  <= 1'b0;
         iload_q <= 32'h0000_0000;
         dload_q <= 32'h0000_0000;
         merr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         data_q  <= data_d;
         addr_q  <= addr_d;
         store_q <= store_d;
         cnt_q   <= cnt_d;
         ihit_q  <= ihit_d;
         dhit_q  <= dhit_d;
         iload_q <= iload_d;
         dload_q <= dload_d;
         merr_q  <= merr_d;
      end
   end

   // RAM side is decoded purely from registered state and latches, so live
   // request inputs never reach the RAM and reset forces it to zero at once.
   always_comb begin
      acc_s    = (state_q == ST_DACC) || (state_q == ST_IACC);
      ramREN   = acc_s & ~wr_q;
      ramWEN   = acc_s & wr_q;
      ramaddr  = acc_s ? addr_q : 32'h0000_0000;
      ramstore = (acc_s && wr_q) ? store_q : 32'h0000_0000;
   end

   assign ihit  = ihit_q;
   assign dhit  = dhit_q;
   assign iload = iload_q;
   assign dload = dload_q;
   assign merr  = merr_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed testbench for memory_arbiter (TIMEOUT = 16). Inputs are driven
// 2 time units after the rising edge and outputs are checked there too.
module tb_memory_arbiter;

   logic        CLK;
   logic        nRST;
   logic        iREN;
   logic [31:0] iaddr;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic        ihit;
   logic [31:0] iload;
   logic        dhit;
   logic [31:0] dload;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   logic [1:0]  ramstate;
   logic        merr;

   int checks = 0;
   int errors = 0;

   localparam logic [1:0] FREE   = 2'd0;
   localparam logic [1:0] BUSY   = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;
   localparam logic [1:0] ERROR  = 2'd3;

   memory_arbiter #(.TIMEOUT(16)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate), .merr(merr)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #2;
   endtask

   task automatic chk_all_zero(input string tag);
      chk1({tag, "_ihit"}, ihit, 1'b0);
      chk1({tag, "_dhit"}, dhit, 1'b0);
      chk32({tag, "_iload"}, iload, 32'h0);
      chk32({tag, "_dload"}, dload, 32'h0);
      chk1({tag, "_merr"}, merr, 1'b0);
      chk1({tag, "_ramREN"}, ramREN, 1'b0);
      chk1({tag, "_ramWEN"}, ramWEN, 1'b0);
      chk32({tag, "_ramaddr"}, ramaddr, 32'h0);
      chk32({tag, "_ramstore"}, ramstore, 32'h0);
   endtask

   initial begin
      int n;
      nRST = 1'b1;
      iREN = 1'b0; iaddr = 32'h0;
      dREN = 1'b0; dWEN = 1'b0; daddr = 32'h0; dstore = 32'h0;
      ramload = 32'h0; ramstate = FREE;
      #1 nRST = 1'b0;
      #2;
      chk_all_zero("reset");
      #9 nRST = 1'b1;
      step();
      chk1("idle_ramREN", ramREN, 1'b0);

      // Single fetch, RAM answers in the first access cycle
      iREN = 1'b1; iaddr = 32'h0000_0100; ramstate = ACCESS; ramload = 32'h8C01_0004;
      step();
      chk1("f1_ramREN", ramREN, 1'b1);
      chk1("f1_ramWEN", ramWEN, 1'b0);
      chk32("f1_ramaddr", ramaddr, 32'h0000_0100);
      chk1("f1_ihit_early", ihit, 1'b0);
      step();
      chk1("f1_ihit", ihit, 1'b1);
      chk1("f1_dhit", dhit, 1'b0);
      chk32("f1_iload", iload, 32'h8C01_0004);
      chk1("f1_resp_ramREN", ramREN, 1'b0);
      chk32("f1_resp_ramaddr", ramaddr, 32'h0);
      iREN = 1'b0;
      step();
      chk1("f1_ihit_drop", ihit, 1'b0);
      chk32("f1_iload_held", iload, 32'h8C01_0004);

      // Simultaneous fetch and data read: data goes first
      iREN = 1'b1; iaddr = 32'h0000_0104;
      dREN = 1'b1; daddr = 32'h0000_0200; ramload = 32'h1111_2222;
      step();
      chk32("pri_ramaddr_d", ramaddr, 32'h0000_0200);
      chk1("pri_ramREN_d", ramREN, 1'b1);
      step();
      chk1("pri_dhit", dhit, 1'b1);
      chk1("pri_no_ihit", ihit, 1'b0);
      chk32("pri_dload", dload, 32'h1111_2222);
      dREN = 1'b0; ramload = 32'h3333_4444;
      step();
      chk1("pri_idle_dhit", dhit, 1'b0);
      chk1("pri_idle_ihit", ihit, 1'b0);
      step();
      chk32("pri_ramaddr_i", ramaddr, 32'h0000_0104);
      step();
      chk1("pri_ihit", ihit, 1'b1);
      chk1("pri_no_dhit", dhit, 1'b0);
      chk32("pri_iload", iload, 32'h3333_4444);
      chk32("pri_dload_held", dload, 32'h1111_2222);
      iREN = 1'b0;
      step();

      // Data write with 3 BUSY cycles; latched values must stay put
      dWEN = 1'b1; daddr = 32'h0000_0040; dstore = 32'hDEAD_BEEF; ramstate = BUSY;
      step();
      for (int i = 0; i < 4; i++) begin
         chk1("wr_ramWEN", ramWEN, 1'b1);
         chk1("wr_ramREN", ramREN, 1'b0);
         chk32("wr_ramstore", ramstore, 32'hDEAD_BEEF);
         chk32("wr_ramaddr", ramaddr, 32'h0000_0040);
         chk1("wr_dhit_early", dhit, 1'b0);
         if (i == 1) begin
            dstore = 32'h0BAD_F00D; daddr = 32'h0000_0999;
         end
         ramstate = (i == 3) ? ACCESS : BUSY;
         step();
      end
      chk1("wr_dhit", dhit, 1'b1);
      chk1("wr_ramWEN_off", ramWEN, 1'b0);
      chk32("wr_dload_unchanged", dload, 32'h1111_2222);
      dWEN = 1'b0;
      step();
      chk1("wr_dhit_drop", dhit, 1'b0);

      // RAM error during fetch
      iREN = 1'b1; iaddr = 32'h0000_0300; ramstate = ERROR; ramload = 32'h7777_7777;
      step();
      chk1("err_ramREN", ramREN, 1'b1);
      chk1("err_merr_pre", merr, 1'b0);
      step();
      chk1("err_ihit", ihit, 1'b1);
      chk32("err_iload", iload, 32'h0);
      chk1("err_merr", merr, 1'b1);
      iREN = 1'b0; ramstate = FREE;
      step();
      chk1("err_merr_sticky", merr, 1'b1);

      // Reset in the middle of a data access, then held request restarts
      dREN = 1'b1; daddr = 32'h0000_0500; ramstate = BUSY;
      step();
      chk1("rst_ramREN_pre", ramREN, 1'b1);
      nRST = 1'b0;
      #1;
      chk_all_zero("rst_async");
      step();
      chk1("rst_no_dhit", dhit, 1'b0);
      chk1("rst_hold_ramREN", ramREN, 1'b0);
      nRST = 1'b1; ramstate = ACCESS; ramload = 32'h55AA_55AA;
      step();
      chk32("rst_reacc_ramaddr", ramaddr, 32'h0000_0500);
      chk1("rst_reacc_ramREN", ramREN, 1'b1);
      step();
      chk1("rst_reacc_dhit", dhit, 1'b1);
      chk32("rst_reacc_dload", dload, 32'h55AA_55AA);
      dREN = 1'b0;
      step();

      // Timeout: RAM stays BUSY, forced completion after 16 pending cycles
      dREN = 1'b1; daddr = 32'h0000_0080; ramstate = BUSY; ramload = 32'hFFFF_FFFF;
      step();
      n = 0;
      while (ramREN && n < 40) begin
         chk1("tmo_dhit_early", dhit, 1'b0);
         n++;
         step();
      end
      chk32("tmo_pending_cycles", 32'(n), 32'd16);
      chk1("tmo_dhit", dhit, 1'b1);
      chk32("tmo_dload", dload, 32'h0);
      chk1("tmo_merr", merr, 1'b1);
      dREN = 1'b0; ramstate = FREE;
      step();
      chk1("tmo_dhit_drop", dhit, 1'b0);
      step();
      step();
      chk1("tmo_merr_sticky", merr, 1'b1);
      nRST = 1'b0;
      #1;
      chk1("final_merr_clear", merr, 1'b0);
      nRST = 1'b1;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
